// File: rtl/mcu_rcc_clkseq.sv
// RCC system-clock sequencer: PLL bring-up/lock qualification and glitch-free HSI/HSE/PLL switching.
// Optional clock security system on HSE loss: define MCU_RCC_CSS_EN.
`timescale 1ns/1ps
module mcu_rcc_clkseq #(
  parameter int LOCK_TIMEOUT  = 1023,
  parameter int SETTLE_CYCLES = 16,
  parameter int GATE_CYCLES   = 2
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       PLLON_REQ,
  input  logic [1:0] SW_REQ,
  input  logic       HSE_RDY,
  input  logic       PLL_LOCK,
  input  logic       FAULT_CLR,
  output logic       PLL_EN,
  output logic       CLK_GATE,
  output logic [1:0] CLKSEL,
  output logic [1:0] SWS,
  output logic       PLLRDY,
  output logic       BUSY,
  output logic       FAULT
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_TMO    = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GATE   = CW'(GATE_CYCLES - 1);
  localparam logic [1:0] SRC_HSI = 2'b00;
  localparam logic [1:0] SRC_HSE = 2'b01;
  localparam logic [1:0] SRC_PLL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_WAIT  = 3'd1,
    ST_PLL_SETTLE= 3'd2,
    ST_SW_GATE   = 3'd3,
    ST_SW_MUX    = 3'd4,
    ST_SW_UNGATE = 3'd5
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    tgt_r;
  logic          lock_meta_r, lock_sync_r;
  logic          pll_en_r, gate_r, pllrdy_r, busy_r, fault_r;
  logic [1:0]    clksel_r, sws_r;
  logic          lock_loss_s, hse_loss_s, force_hsi_s, tgt_ready_s, sw_go_s;

  assign lock_loss_s = pllrdy_r & ~lock_sync_r;
`ifdef MCU_RCC_CSS_EN
  assign hse_loss_s  = (sws_r == SRC_HSE) & ~HSE_RDY;
`else
  assign hse_loss_s  = 1'b0;
`endif
  assign force_hsi_s = (lock_loss_s & (sws_r == SRC_PLL)) | hse_loss_s;
  assign sw_go_s     = (SW_REQ != sws_r) & tgt_ready_s;

  // Readiness of the requested source; the reserved code is never ready.
  always_comb begin
    tgt_ready_s = 1'b0;
    case (SW_REQ)
      SRC_HSI: tgt_ready_s = 1'b1;
      SRC_HSE: tgt_ready_s = HSE_RDY;
      SRC_PLL: tgt_ready_s = pllrdy_r;
      default: tgt_ready_s = 1'b0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= PLL_LOCK;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Sequencer FSM; a fault set later in this block overrides a same-cycle clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      tgt_r    <= SRC_HSI;
      pll_en_r <= 1'b0;
      gate_r   <= 1'b0;
      clksel_r <= SRC_HSI;
      sws_r    <= SRC_HSI;
      pllrdy_r <= 1'b0;
      busy_r   <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      if (FAULT_CLR) fault_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (lock_loss_s || hse_loss_s) begin
            fault_r <= 1'b1;
            if (lock_loss_s) pllrdy_r <= 1'b0;
            if (force_hsi_s) begin
              tgt_r   <= SRC_HSI;
              state_r <= ST_SW_GATE;
              gate_r  <= 1'b1;
              busy_r  <= 1'b1;
              cnt_r   <= CNT_ZERO;
            end
          end else if (PLLON_REQ && !pll_en_r) begin
            pll_en_r <= 1'b1;
            cnt_r    <= CNT_ZERO;
            state_r  <= ST_PLL_WAIT;
            busy_r   <= 1'b1;
          end else if (!PLLON_REQ && pll_en_r && (sws_r != SRC_PLL)) begin
            pll_en_r <= 1'b0;
            pllrdy_r <= 1'b0;
          end else if (sw_go_s) begin
            tgt_r   <= SW_REQ;
            state_r <= ST_SW_GATE;
            gate_r  <= 1'b1;
            busy_r  <= 1'b1;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_PLL_WAIT: begin
          if (lock_sync_r) begin
            state_r <= ST_PLL_SETTLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_TMO) begin
            pll_en_r <= 1'b0;
            fault_r  <= 1'b1;
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end else if (!PLLON_REQ) begin
            pll_en_r <= 1'b0;
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_PLL_SETTLE: begin
          if (!lock_sync_r) begin
            state_r <= ST_PLL_WAIT;
            cnt_r   <= CNT_ZERO;
          end else if (!PLLON_REQ) begin
            pll_en_r <= 1'b0;
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end else if (cnt_r == CNT_SETTLE) begin
            pllrdy_r <= 1'b1;
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SW_GATE: begin
          if (cnt_r == CNT_GATE) begin
            clksel_r <= tgt_r;
            sws_r    <= tgt_r;
            state_r  <= ST_SW_MUX;
            cnt_r    <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SW_MUX: begin
          if (cnt_r == CNT_GATE) begin
            gate_r  <= 1'b0;
            state_r <= ST_SW_UNGATE;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SW_UNGATE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          gate_r  <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign PLL_EN   = pll_en_r;
  assign CLK_GATE = gate_r;
  assign CLKSEL   = clksel_r;
  assign SWS      = sws_r;
  assign PLLRDY   = pllrdy_r;
  assign BUSY     = busy_r;
  assign FAULT    = fault_r;

endmodule

// File: tb/tb_mcu_rcc_clkseq.sv
// Directed self-checking bench for mcu_rcc_clkseq (default parameters).
`timescale 1ns/1ps
module tb_mcu_rcc_clkseq;

  logic       HCLK = 1'b0;
  logic       HRESET, PLLON_REQ, HSE_RDY, PLL_LOCK, FAULT_CLR;
  logic [1:0] SW_REQ;
  logic       PLL_EN, CLK_GATE, PLLRDY, BUSY, FAULT;
  logic [1:0] CLKSEL, SWS;
  int         n_total = 0;
  int         n_pass  = 0;

  mcu_rcc_clkseq dut (
    .HCLK(HCLK), .HRESET(HRESET), .PLLON_REQ(PLLON_REQ), .SW_REQ(SW_REQ),
    .HSE_RDY(HSE_RDY), .PLL_LOCK(PLL_LOCK), .FAULT_CLR(FAULT_CLR),
    .PLL_EN(PLL_EN), .CLK_GATE(CLK_GATE), .CLKSEL(CLKSEL), .SWS(SWS),
    .PLLRDY(PLLRDY), .BUSY(BUSY), .FAULT(FAULT)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; PLLON_REQ = 1'b0; SW_REQ = 2'b00; HSE_RDY = 1'b0;
    PLL_LOCK = 1'b0; FAULT_CLR = 1'b0;
    tick(3);
    HRESET = 1'b0;
    tick(1);
    chk("rst_pll_en", {3'b0, PLL_EN}, 4'h0);
    chk("rst_gate",   {3'b0, CLK_GATE}, 4'h0);
    chk("rst_clksel", {2'b0, CLKSEL}, 4'h0);
    chk("rst_sws",    {2'b0, SWS}, 4'h0);
    chk("rst_pllrdy", {3'b0, PLLRDY}, 4'h0);
    chk("rst_busy",   {3'b0, BUSY}, 4'h0);
    chk("rst_fault",  {3'b0, FAULT}, 4'h0);

    // reset in the middle of SW_GATE
    SW_REQ = 2'b01; HSE_RDY = 1'b1;
    tick(1);
    chk("midsw_gate_on", {3'b0, CLK_GATE}, 4'h1);
    #2 HRESET = 1'b1;
    #1;
    chk("midsw_gate_off", {3'b0, CLK_GATE}, 4'h0);
    chk("midsw_clksel",   {2'b0, CLKSEL}, 4'h0);
    chk("midsw_busy",     {3'b0, BUSY}, 4'h0);
    SW_REQ = 2'b00; HSE_RDY = 1'b0;
    tick(1);
    HRESET = 1'b0;
    tick(1);

    // PLL bring-up, lock 50 cycles after the request
    PLLON_REQ = 1'b1;
    tick(1);
    chk("pllon_en",   {3'b0, PLL_EN}, 4'h1);
    chk("pllon_busy", {3'b0, BUSY}, 4'h1);
    tick(49);
    PLL_LOCK = 1'b1;
    tick(18);
    chk("pllrdy_early", {3'b0, PLLRDY}, 4'h0);
    tick(1);
    chk("pllrdy_set",  {3'b0, PLLRDY}, 4'h1);
    chk("pllrdy_busy", {3'b0, BUSY}, 4'h0);
    chk("pllrdy_fault",{3'b0, FAULT}, 4'h0);

    // switch to PLL: request sampled at cycle N
    SW_REQ = 2'b10;
    tick(1);
    chk("sw_n1_gate",   {3'b0, CLK_GATE}, 4'h1);
    chk("sw_n1_clksel", {2'b0, CLKSEL}, 4'h0);
    tick(1);
    chk("sw_n2_clksel", {2'b0, CLKSEL}, 4'h0);
    tick(1);
    chk("sw_n3_clksel", {2'b0, CLKSEL}, 4'h2);
    chk("sw_n3_sws",    {2'b0, SWS}, 4'h2);
    chk("sw_n3_gate",   {3'b0, CLK_GATE}, 4'h1);
    tick(1);
    chk("sw_n4_gate",   {3'b0, CLK_GATE}, 4'h1);
    tick(1);
    chk("sw_n5_gate",   {3'b0, CLK_GATE}, 4'h0);
    chk("sw_n5_busy",   {3'b0, BUSY}, 4'h1);
    tick(1);
    chk("sw_n6_busy",   {3'b0, BUSY}, 4'h0);

    // HSE not ready: request stays pending
    SW_REQ = 2'b01;
    tick(3);
    chk("hse_nrdy_sws",  {2'b0, SWS}, 4'h2);
    chk("hse_nrdy_busy", {3'b0, BUSY}, 4'h0);
    SW_REQ = 2'b10;

    // PLL off refused while running from PLL
    PLLON_REQ = 1'b0;
    tick(3);
    chk("off_refused_en", {3'b0, PLL_EN}, 4'h1);
    PLLON_REQ = 1'b1;

    // lock loss while on PLL forces HSI
    PLL_LOCK = 1'b0;
    tick(3);
    chk("lost_pllrdy", {3'b0, PLLRDY}, 4'h0);
    chk("lost_fault",  {3'b0, FAULT}, 4'h1);
    chk("lost_gate",   {3'b0, CLK_GATE}, 4'h1);
    tick(5);
    chk("lost_sws",    {2'b0, SWS}, 4'h0);
    chk("lost_clksel", {2'b0, CLKSEL}, 4'h0);
    chk("lost_busy",   {3'b0, BUSY}, 4'h0);
    SW_REQ = 2'b00;
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
    chk("lost_clr", {3'b0, FAULT}, 4'h0);
    PLLON_REQ = 1'b0;
    tick(1);
    chk("off_ok_en", {3'b0, PLL_EN}, 4'h0);

    // lock timeout
    PLLON_REQ = 1'b1;
    tick(1);
    chk("tmo_en_on", {3'b0, PLL_EN}, 4'h1);
    tick(1023);
    chk("tmo_en_hold",  {3'b0, PLL_EN}, 4'h1);
    chk("tmo_no_fault", {3'b0, FAULT}, 4'h0);
    PLLON_REQ = 1'b0;
    tick(1);
    chk("tmo_en_off", {3'b0, PLL_EN}, 4'h0);
    chk("tmo_fault",  {3'b0, FAULT}, 4'h1);
    chk("tmo_busy",   {3'b0, BUSY}, 4'h0);
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
    chk("tmo_clr", {3'b0, FAULT}, 4'h0);

    // HSE loss while running from HSE
    HSE_RDY = 1'b1; SW_REQ = 2'b01;
    tick(6);
    chk("hse_sws",  {2'b0, SWS}, 4'h1);
    chk("hse_busy", {3'b0, BUSY}, 4'h0);
    HSE_RDY = 1'b0;
    tick(7);
`ifdef MCU_RCC_CSS_EN
    chk("css_sws",   {2'b0, SWS}, 4'h0);
    chk("css_fault", {3'b0, FAULT}, 4'h1);
`else
    chk("css_sws",   {2'b0, SWS}, 4'h1);
    chk("css_fault", {3'b0, FAULT}, 4'h0);
`endif
    chk("css_busy", {3'b0, BUSY}, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
